// File: rtl/conv_pe_array.sv
// Multi-filter convolution engine: K-tap sliding window over a pixel stream,
// dot product against NPE stored filters, results drained one channel per handshake.
module conv_pe_array #(
  parameter int DW     = 8,
  parameter int K      = 16,
  parameter int NPE    = 4,
  parameter int STRIDE = 1,
  parameter int SIGNED = 0,
  parameter int ACCW   = 2*DW + $clog2(K)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flt_wr_en,
  input  logic [((NPE > 1) ? $clog2(NPE) : 1)-1:0] flt_sel,
  input  logic [$clog2(K)-1:0]                  flt_addr,
  input  logic [DW-1:0]                         flt_data,
  output logic                                  flt_busy,
  input  logic                                  clr,
  input  logic                                  pix_valid,
  output logic                                  pix_ready,
  input  logic [DW-1:0]                         pix_data,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [ACCW-1:0]                       res_data,
  output logic [((NPE > 1) ? $clog2(NPE) : 1)-1:0] res_ch
);

  localparam int SW = (NPE > 1) ? $clog2(NPE) : 1;
  localparam int AW = $clog2(K);
  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {LOAD, MAC, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     filled_q, filled_d;
  logic [CW-1:0]     need_q, need_d;
  logic [AW-1:0]     k_q, k_d;
  logic [SW-1:0]     ch_q, ch_d;
  logic [ACCW-1:0]   acc_q [NPE];
  logic [ACCW-1:0]   acc_d [NPE];
  logic [DW-1:0]     flt_q [NPE][K];
  logic [DW-1:0]     flt_d [NPE][K];
  logic [DW-1:0]     win_q [K];
  logic [DW-1:0]     win_d [K];

  // Product extended to accumulator width; sign-extended only in signed mode.
  function automatic logic [ACCW-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [2*DW-1:0] sp;
    logic [2*DW-1:0]        up;
    sp = $signed(a) * $signed(b);
    up = a * b;
    if (SIGNED != 0) mul_ext = {{(ACCW-2*DW){sp[2*DW-1]}}, sp};
    else             mul_ext = {{(ACCW-2*DW){1'b0}}, up};
  endfunction

  always_comb begin
    state_d   = state_q;
    filled_d  = filled_q;
    need_d    = need_q;
    k_d       = k_q;
    ch_d      = ch_q;
    acc_d     = acc_q;
    flt_d     = flt_q;
    win_d     = win_q;
    pix_ready = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    res_ch    = ch_q;
    flt_busy  = (state_q != LOAD);

    case (state_q)
      LOAD: begin
        pix_ready = !rst && !clr;
        // Write lands before the window completes, so the next MAC sees it.
        if (flt_wr_en && (32'(flt_sel) < NPE) && (32'(flt_addr) < K))
          flt_d[flt_sel][flt_addr] = flt_data;
        if (clr) begin
          filled_d = '0;
          need_d   = CW'(K);
        end else if (pix_valid) begin
          for (int i = 0; i < K-1; i++) win_d[i] = win_q[i+1];
          win_d[K-1] = pix_data;
          filled_d   = filled_q + CW'(1);
          if (filled_d == need_q) begin
            for (int p = 0; p < NPE; p++) acc_d[p] = '0;
            k_d     = '0;
            state_d = MAC;
          end
        end
      end
      MAC: begin
        for (int p = 0; p < NPE; p++)
          acc_d[p] = acc_q[p] + mul_ext(win_q[k_q], flt_q[p][k_q]);
        k_d = k_q + AW'(1);
        if (k_q == AW'(K-1)) begin
          k_d     = '0;
          ch_d    = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        res_valid = 1'b1;
        res_data  = acc_q[ch_q];
        if (res_ready) begin
          if (ch_q == SW'(NPE-1)) begin
            ch_d     = '0;
            filled_d = '0;
            need_d   = CW'(STRIDE);
            state_d  = LOAD;
          end else begin
            ch_d = ch_q + SW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      filled_q <= '0;
      need_q   <= CW'(K);
      k_q      <= '0;
      ch_q     <= '0;
      for (int p = 0; p < NPE; p++) begin
        acc_q[p] <= '0;
        for (int i = 0; i < K; i++) flt_q[p][i] <= '0;
      end
      for (int i = 0; i < K; i++) win_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      filled_q <= filled_d;
      need_q   <= need_d;
      k_q      <= k_d;
      ch_q     <= ch_d;
      acc_q    <= acc_d;
      flt_q    <= flt_d;
      win_q    <= win_d;
    end
  end

endmodule

// File: tb/tb_conv_pe_array.sv
// Bench for conv_pe_array: three instances (K=4, NPE=2) covering stride 1 unsigned,
// stride 2, and signed operands, checked against a window/dot-product model.
module tb_conv_pe_array;

  logic        clk;
  logic        rst;
  logic        flt_wr_en [3];
  logic        flt_sel   [3];
  logic [1:0]  flt_addr  [3];
  logic [7:0]  flt_data  [3];
  logic        flt_busy  [3];
  logic        clr       [3];
  logic        pix_valid [3];
  logic        pix_ready [3];
  logic [7:0]  pix_data  [3];
  logic        res_valid [3];
  logic        res_ready [3];
  logic [17:0] res_data  [3];
  logic        res_ch    [3];

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          g;
    logic        ch;
    logic [17:0] d;
  } res_t;
  res_t got[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    conv_pe_array #(
      .DW(8), .K(4), .NPE(2),
      .STRIDE((g == 1) ? 2 : 1),
      .SIGNED((g == 2) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst),
      .flt_wr_en(flt_wr_en[g]), .flt_sel(flt_sel[g]), .flt_addr(flt_addr[g]),
      .flt_data(flt_data[g]), .flt_busy(flt_busy[g]), .clr(clr[g]),
      .pix_valid(pix_valid[g]), .pix_ready(pix_ready[g]), .pix_data(pix_data[g]),
      .res_valid(res_valid[g]), .res_ready(res_ready[g]),
      .res_data(res_data[g]), .res_ch(res_ch[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 = collecting pixels, 1 = computing (K cycles), 2 = presenting results
  int          m_phase [3];
  int          m_cd    [3];
  int          m_cnt   [3];
  int          m_need  [3];
  int          m_ch    [3];
  logic [7:0]  m_flt   [3][2][4];
  logic [7:0]  m_win   [3][4];
  logic [17:0] m_exp   [3][2];

  function automatic logic [17:0] dot(input int g, input int p);
    longint s, a, b;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      if (g == 2) begin
        a = longint'($signed(m_win[g][k]));
        b = longint'($signed(m_flt[g][p][k]));
      end else begin
        a = longint'(m_win[g][k]);
        b = longint'(m_flt[g][p][k]);
      end
      s = s + a * b;
    end
    return s[17:0];
  endfunction

  always @(negedge clk) begin : cmp
    logic        e_valid;
    logic [17:0] e_data;
    for (int g = 0; g < 3; g++) begin
      e_valid = (m_phase[g] == 2);
      e_data  = e_valid ? m_exp[g][m_ch[g]] : 18'd0;
      check($sformatf("pix_ready[%0d]", g), 32'(pix_ready[g]), 32'((m_phase[g] == 0) && !rst && !clr[g]));
      check($sformatf("res_valid[%0d]", g), 32'(res_valid[g]), 32'(e_valid));
      check($sformatf("res_data[%0d]", g), 32'(res_data[g]), 32'(e_data));
      check($sformatf("res_ch[%0d]", g), 32'(res_ch[g]), 32'(m_ch[g]));
      check($sformatf("flt_busy[%0d]", g), 32'(flt_busy[g]), 32'(m_phase[g] != 0));
      if (res_valid[g] && res_ready[g]) got.push_back('{g, res_ch[g], res_data[g]});

      if (rst) begin
        m_phase[g] = 0; m_cd[g] = 0; m_cnt[g] = 0; m_need[g] = 4; m_ch[g] = 0;
        for (int k = 0; k < 4; k++) begin
          m_win[g][k] = '0;
          m_flt[g][0][k] = '0;
          m_flt[g][1][k] = '0;
        end
      end else begin
        case (m_phase[g])
          0: begin
            if (flt_wr_en[g]) m_flt[g][flt_sel[g]][flt_addr[g]] = flt_data[g];
            if (clr[g]) begin
              m_cnt[g] = 0; m_need[g] = 4;
            end else if (pix_valid[g]) begin
              for (int k = 0; k < 3; k++) m_win[g][k] = m_win[g][k+1];
              m_win[g][3] = pix_data[g];
              m_cnt[g]++;
              if (m_cnt[g] == m_need[g]) begin
                m_exp[g][0] = dot(g, 0);
                m_exp[g][1] = dot(g, 1);
                m_phase[g] = 1; m_cd[g] = 4;
              end
            end
          end
          1: begin
            m_cd[g]--;
            if (m_cd[g] == 0) begin m_phase[g] = 2; m_ch[g] = 0; end
          end
          default: begin
            if (res_ready[g]) begin
              if (m_ch[g] == 1) begin
                m_phase[g] = 0; m_cnt[g] = 0; m_need[g] = (g == 1) ? 2 : 1; m_ch[g] = 0;
              end else m_ch[g]++;
            end
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_flt(input int g, input int sel, input int addr, input int d);
    flt_wr_en[g] = 1'b1; flt_sel[g] = sel[0]; flt_addr[g] = addr[1:0]; flt_data[g] = d[7:0];
    tick();
    flt_wr_en[g] = 1'b0;
  endtask

  task automatic load_flt(input int g);
    for (int k = 0; k < 4; k++) begin
      wr_flt(g, 0, k, k + 1);
      wr_flt(g, 1, k, 1);
    end
  endtask

  task automatic push(input int g, input int d);
    int  n;
    bit  acc;
    n = 0; acc = 0;
    pix_valid[g] = 1'b1; pix_data[g] = d[7:0];
    while (!acc && n < 100) begin
      @(negedge clk);
      if (pix_ready[g]) acc = 1;
      tick();
      n++;
    end
    pix_valid[g] = 1'b0;
    check($sformatf("push_accept[%0d]", g), 32'(acc), 32'd1);
  endtask

  task automatic pulse_clr(input int g);
    clr[g] = 1'b1;
    tick();
    clr[g] = 1'b0;
  endtask

  task automatic wait_res(input int g, input int ch, input int d);
    int   n;
    res_t r;
    n = 0;
    while (got.size() == 0 && n < 100) begin tick(); n++; end
    check($sformatf("result_arrived[%0d]", g), 32'(got.size() > 0), 32'd1);
    if (got.size() > 0) begin
      r = got.pop_front();
      check("result_inst", 32'(r.g), 32'(g));
      check($sformatf("result_ch[%0d]", g), 32'(r.ch), 32'(ch));
      check($sformatf("result_data[%0d]", g), 32'(r.d), 32'(d));
    end
  endtask

  task automatic wait_valid(input int g);
    int n;
    n = 0;
    while (!res_valid[g] && n < 50) begin tick(); n++; end
    check($sformatf("valid_arrived[%0d]", g), 32'(res_valid[g]), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      flt_wr_en[g] = 0; flt_sel[g] = 0; flt_addr[g] = 0; flt_data[g] = 0;
      clr[g] = 0; pix_valid[g] = 0; pix_data[g] = 0; res_ready[g] = 1;
    end
    repeat (3) tick();
    check("rst_pix_ready", 32'(pix_ready[0]), 32'd0);
    check("rst_res_valid", 32'(res_valid[0]), 32'd0);
    check("rst_res_data", 32'(res_data[0]), 32'd0);
    check("rst_flt_busy", 32'(flt_busy[0]), 32'd0);
    rst = 1'b0;
    #1;
    check("pix_ready_after_rst", 32'(pix_ready[0]), 32'd1);
    tick();

    // Basic window and latency
    load_flt(0);
    push(0, 1); push(0, 2); push(0, 3); push(0, 4);
    n = 0;
    while (!res_valid[0] && n < 20) begin tick(); n++; end
    check("latency", 32'(n), 32'd4);
    wait_res(0, 0, 30); wait_res(0, 1, 10);
    push(0, 5);
    wait_res(0, 0, 40); wait_res(0, 1, 14);

    // Backpressure holds the result
    res_ready[0] = 1'b0;
    push(0, 6);
    wait_valid(0);
    repeat (3) begin
      check("hold_data", 32'(res_data[0]), 32'd50);
      check("hold_ch", 32'(res_ch[0]), 32'd0);
      check("hold_pix_ready", 32'(pix_ready[0]), 32'd0);
      tick();
    end
    res_ready[0] = 1'b1;
    wait_res(0, 0, 50); wait_res(0, 1, 18);

    // Filter write during MAC is ignored
    push(0, 7);
    tick();
    wr_flt(0, 0, 0, 9);
    wait_res(0, 0, 60); wait_res(0, 1, 22);

    // clr beats pix_valid, then discards a partial window
    clr[0] = 1'b1; pix_valid[0] = 1'b1; pix_data[0] = 8'd99;
    #1;
    check("clr_blocks_ready", 32'(pix_ready[0]), 32'd0);
    tick();
    clr[0] = 1'b0; pix_valid[0] = 1'b0;
    push(0, 8); push(0, 8);
    pulse_clr(0);
    push(0, 1); push(0, 2); push(0, 3);
    repeat (8) tick();
    check("no_early_result", 32'(got.size()), 32'd0);
    check("no_early_valid", 32'(res_valid[0]), 32'd0);
    push(0, 4);
    wait_res(0, 0, 30); wait_res(0, 1, 10);

    // Reset mid-drain loses the result and clears filters
    res_ready[0] = 1'b0;
    push(0, 5);
    wait_valid(0);
    check("pre_rst_data", 32'(res_data[0]), 32'd40);
    rst = 1'b1;
    tick();
    check("post_rst_valid", 32'(res_valid[0]), 32'd0);
    check("post_rst_busy", 32'(flt_busy[0]), 32'd0);
    rst = 1'b0;
    res_ready[0] = 1'b1;
    tick();
    check("lost_result", 32'(got.size()), 32'd0);
    push(0, 1); push(0, 2); push(0, 3); push(0, 4);
    wait_res(0, 0, 0); wait_res(0, 1, 0);

    // Unsigned 0xFF window
    load_flt(0);
    pulse_clr(0);
    repeat (4) push(0, 255);
    wait_res(0, 0, 32'h009F6); wait_res(0, 1, 32'h003FC);

    // Stride 2, with a same-cycle filter write on the completing pixel
    load_flt(1);
    push(1, 1); push(1, 2); push(1, 3); push(1, 4);
    wait_res(1, 0, 30); wait_res(1, 1, 10);
    push(1, 5);
    repeat (12) tick();
    check("stride_no_result", 32'(got.size()), 32'd0);
    check("stride_no_valid", 32'(res_valid[1]), 32'd0);
    flt_wr_en[1] = 1'b1; flt_sel[1] = 1'b1; flt_addr[1] = 2'd3; flt_data[1] = 8'd2;
    push(1, 6);
    flt_wr_en[1] = 1'b0;
    wait_res(1, 0, 50); wait_res(1, 1, 24);

    // Signed operands
    load_flt(2);
    repeat (4) push(2, 255);
    wait_res(2, 0, 32'h3FFF6); wait_res(2, 1, 32'h3FFFC);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
